// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame field order.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Frame layout on the byte stream: length, payload, checksum.
  localparam int FIELD_LEN  = 0;
  localparam int FIELD_DATA = 1;
  localparam int FIELD_CSUM = 2;

endpackage

// File: rtl/program_loader_pm_write_reg.sv
// Registered write port toward program memory: one enable pulse per captured byte,
// address/data hold their last value between pulses.
module program_loader_pm_write_reg #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [ADD_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  wr_en,
  output logic [ADD_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= capture;
      if (capture) begin
        wr_addr <= addr;
        wr_data <= data;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream (LEN, payload, XOR checksum) into program memory and
// releases the CPU only after a frame with a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic                  pmWrEn,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] instructionIn,
  output logic                  cpu_run,
  output logic                  load_err,
  output state_t                state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends on state only, and a byte offered while ready=0 stays pending.

  localparam logic [ADD_WIDTH:0] FULL = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [ADD_WIDTH:0] ONE  = {{ADD_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADD_WIDTH:0]    cnt, total, cnt_inc;
  logic [DATA_WIDTH-1:0] csum;
  logic                  accept, start_ok, capture;
  logic [ADD_WIDTH-1:0]  len_low;

  assign state    = state_q;
  assign accept   = byte_valid && byte_ready;
  assign cnt_inc  = cnt + ONE;
  assign len_low  = byte_data[ADD_WIDTH-1:0];
  assign start_ok = load_start &&
                    (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign capture  = (state_q == S_DATA) && accept;

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (load_start) state_d = S_LEN;
      S_LEN: begin
        byte_ready = 1'b1;
        if (accept) state_d = S_DATA;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (accept && cnt_inc == total) state_d = S_CSUM;
      end
      S_CSUM: begin
        byte_ready = 1'b1;
        if (accept) state_d = (byte_data == csum) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt      <= '0;
      total    <= '0;
      csum     <= '0;
      cpu_run  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        cpu_run  <= 1'b0;
        load_err <= 1'b0;
        cnt      <= '0;
        csum     <= '0;
      end
      // A zero length field stands for a full-memory frame.
      if (state_q == S_LEN && accept)
        total <= (len_low == '0) ? FULL : {1'b0, len_low};
      if (capture) begin
        csum <= csum ^ byte_data;
        cnt  <= cnt_inc;
      end
      if (state_q == S_CSUM && accept) begin
        if (byte_data == csum) cpu_run  <= 1'b1;
        else                   load_err <= 1'b1;
      end
    end
  end

  program_loader_pm_write_reg #(
    .ADD_WIDTH (ADD_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pm_write_reg (
    .clk    (clk),
    .rst    (rst),
    .capture(capture),
    .addr   (cnt[ADD_WIDTH-1:0]),
    .data   (byte_data),
    .wr_en  (pmWrEn),
    .wr_addr(pm_addr),
    .wr_data(instructionIn)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scenario tasks against a frame-level reference model.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int W = 32 + 7 + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready, pmWrEn, cpu_run, load_err;
  logic [6:0] pm_addr;
  logic [7:0] instructionIn;
  state_t     state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;

  logic [7:0]   pay[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_q[$];

  program_loader #(.ADD_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .pmWrEn       (pmWrEn),
    .pm_addr      (pm_addr),
    .instructionIn(instructionIn),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .state        (state)
  );

  // clock / cycle stamp / write monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pmWrEn === 1'b1) wr_q.push_back({32'(cyc), pm_addr, instructionIn});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Offer one byte until it is accepted; stamps the cycle it was presented.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    while (!done && tries < 500) begin
      @(negedge clk);
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? b : 8'($urandom);
      if (byte_valid && byte_ready) begin
        done     = 1'b1;
        last_acc = cyc;
      end
      tries++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_byte_timeout: byte %h got not accepted, required accepted", b);
    end
  endtask

  // Sends load_start, LEN, the payload in pay[], then csum_byte; checks the outcome
  // against the frame model (expected writes, checksum verdict).
  task automatic do_frame(input logic [7:0] len_byte, input logic [7:0] csum_byte,
                          input bit rnd, input bit poke_start);
    logic [7:0] x;
    bit ok;
    int n;
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    n_checks += 3;
    if (state !== S_LEN) begin n_fail++; $display("FAIL start_state: got %0d required %0d", state, S_LEN); end
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL start_cpu_run: got %b required 0", cpu_run); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL start_load_err: got %b required 0", load_err); end

    wr_q.delete();
    exp_q.delete();
    x = 8'h00;
    send_byte(len_byte, rnd);
    for (int i = 0; i < pay.size(); i++) begin
      load_start = 1'b0;
      send_byte(pay[i], rnd);
      exp_q.push_back({32'(last_acc + 1), 7'(i), pay[i]});
      x = x ^ pay[i];
      if (poke_start && i == 1) load_start = 1'b1;
    end
    load_start = 1'b0;
    send_byte(csum_byte, rnd);
    @(negedge clk);
    byte_valid = 1'b0;

    ok = (x == csum_byte);
    n_checks += 5;
    if (state !== (ok ? S_DONE : S_ERR)) begin n_fail++; $display("FAIL end_state: got %0d required %0d", state, ok ? S_DONE : S_ERR); end
    if (cpu_run !== ok) begin n_fail++; $display("FAIL end_cpu_run: got %b required %b", cpu_run, ok); end
    if (load_err !== !ok) begin n_fail++; $display("FAIL end_load_err: got %b required %b", load_err, !ok); end
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL end_byte_ready: got %b required 0", byte_ready); end
    if (pmWrEn !== 1'b0) begin n_fail++; $display("FAIL end_no_write: got %b required 0", pmWrEn); end

    n = (len_byte[6:0] == 7'd0) ? 128 : int'(len_byte[6:0]);
    n_checks += 2;
    if (exp_q.size() !== n) begin n_fail++; $display("FAIL model_len: payload %0d required %0d", exp_q.size(), n); end
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d required %0d", wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL write_%0d: got cyc %0d addr %h data %h required cyc %0d addr %h data %h", i,
                   wr_q[i][W-1:15], wr_q[i][14:8], wr_q[i][7:0], exp_q[i][W-1:15], exp_q[i][14:8], exp_q[i][7:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (state !== S_IDLE) begin n_fail++; $display("FAIL por_state: got %0d required %0d", state, S_IDLE); end
    if (pmWrEn !== 1'b0) begin n_fail++; $display("FAIL por_pmWrEn: got %b required 0", pmWrEn); end
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL por_cpu_run: got %b required 0", cpu_run); end
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL por_byte_ready: got %b required 0", byte_ready); end
    rst = 1'b1;
    // Reset in the middle of a DATA phase.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_byte(8'd10, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required %0d", state, S_IDLE); end
    if (pmWrEn !== 1'b0) begin n_fail++; $display("FAIL rst_pmWrEn: got %b required 0", pmWrEn); end
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_run: got %b required 0", cpu_run); end
    if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst_load_err: got %b required 0", load_err); end
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b required 0", byte_ready); end
    rst = 1'b1;
    wr_q.delete();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    n_checks += 2;
    if (wr_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_writes: got %0d required 0", wr_q.size()); end
    if (state !== S_IDLE) begin n_fail++; $display("FAIL rst_stays_idle: got %0d required %0d", state, S_IDLE); end
  endtask

  task automatic test_good_frame();
    pay = '{8'h13, 8'h05, 8'h10, 8'h00};
    do_frame(8'd4, 8'h06, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    pay = '{8'h13, 8'h05, 8'h10, 8'h00};
    do_frame(8'd4, 8'h07, 1'b0, 1'b0);
    // The next frame's start check covers load_err clearing.
    pay = '{8'h3c};
    do_frame(8'd1, 8'h3c, 1'b0, 1'b0);
  endtask

  task automatic test_full_memory();
    pay.delete();
    for (int i = 0; i < 128; i++) pay.push_back(8'(i));
    do_frame(8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_flow_control();
    int n;
    logic [7:0] x;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(3, 24);
      pay.delete();
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        pay.push_back(8'($urandom));
        x = x ^ pay[i];
      end
      if (r == 2) x = x ^ 8'h80;
      do_frame(8'(n), x, 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back_reload();
    pay = '{8'h21, 8'h42};
    do_frame(8'd2, 8'h63, 1'b0, 1'b0);
    n_checks++;
    if (cpu_run !== 1'b1) begin n_fail++; $display("FAIL reload_pre_cpu_run: got %b required 1", cpu_run); end
    pay = '{8'hAA};
    do_frame(8'd1, 8'hAA, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_full_memory();
    test_flow_control();
    test_back_to_back_reload();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
